// File: rtl/barrier_collision_ctrl.sv
// barrier_collision_ctrl: spawns left/right barriers, resolves collisions and dodges, tracks lives and score
module barrier_collision_ctrl #(
    parameter int         SPAWN_DELAY_FRAMES  = 30,
    parameter int         COOLDOWN_FRAMES     = 15,
    parameter int         MAX_APPROACH_FRAMES = 60,
    parameter int         INIT_LIVES          = 3,
    parameter logic [7:0] LFSR_SEED           = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_v_sync,
    input  logic        i_start,
    input  logic        i_player_hit,
    input  logic        i_barrier_left_hit,
    input  logic        i_barrier_right_hit,
    input  logic        i_in_position_left,
    input  logic        i_in_position_right,
    output logic        o_active_left,
    output logic        o_active_right,
    output logic        o_collision,
    output logic        o_dodge,
    output logic [3:0]  o_lives,
    output logic [15:0] o_score,
    output logic        o_game_over
);
    typedef enum logic [2:0] {IDLE, SPAWN_WAIT, APPROACH, COOLDOWN, GAME_OVER} state_t;

    localparam logic [15:0] SPAWN_N = 16'(SPAWN_DELAY_FRAMES);
    localparam logic [15:0] COOL_N  = 16'(COOLDOWN_FRAMES);
    localparam logic [15:0] APPR_N  = 16'(MAX_APPROACH_FRAMES);
    localparam logic [3:0]  LIVES_N = 4'(INIT_LIVES);

    state_t      state, state_n;
    logic        v_sync_q, tick;
    logic        side, side_n;
    logic        overlap_f, inpos_f;
    logic        sel_hit, sel_inpos, overlap, inpos;
    logic        collision, collision_n, dodge, dodge_n;
    logic [7:0]  lfsr, lfsr_next;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [15:0] score, score_n;
    logic [3:0]  lives, lives_n;

    assign tick      = i_v_sync & ~v_sync_q;
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign sel_hit   = side ? i_barrier_right_hit : i_barrier_left_hit;
    assign sel_inpos = side ? i_in_position_right : i_in_position_left;
    // The tick cycle still belongs to the ending frame, so fold in the live condition
    assign overlap   = overlap_f | (i_player_hit & sel_hit);
    assign inpos     = inpos_f | sel_inpos;
    assign cnt_inc   = cnt + 16'd1;

    assign o_active_left  = (state == APPROACH) && !side;
    assign o_active_right = (state == APPROACH) && side;
    assign o_game_over    = (state == GAME_OVER);
    assign o_collision    = collision;
    assign o_dodge        = dodge;
    assign o_lives        = lives;
    assign o_score        = score;

    // Frame edge detect, side-select LFSR and sticky per-frame flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v_sync_q  <= 1'b0;
            lfsr      <= LFSR_SEED;
            overlap_f <= 1'b0;
            inpos_f   <= 1'b0;
        end else begin
            v_sync_q  <= i_v_sync;
            if (tick && state != IDLE)
                lfsr <= lfsr_next;
            overlap_f <= !tick && (overlap_f || (i_player_hit && sel_hit));
            inpos_f   <= !tick && (inpos_f || sel_inpos);
        end
    end

    // State, frame counter and game registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            side      <= 1'b0;
            lives     <= LIVES_N;
            score     <= 16'd0;
            collision <= 1'b0;
            dodge     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            side      <= side_n;
            lives     <= lives_n;
            score     <= score_n;
            collision <= collision_n;
            dodge     <= dodge_n;
        end
    end

    // Next-state logic, approach resolution and frame counting
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        side_n      = side;
        lives_n     = lives;
        score_n     = score;
        collision_n = 1'b0;
        dodge_n     = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                if (i_start) begin
                    state_n = SPAWN_WAIT;
                    cnt_n   = 16'd0;
                    lives_n = LIVES_N;
                    score_n = 16'd0;
                end
            end
            SPAWN_WAIT: begin
                if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= SPAWN_N) begin
                        state_n = APPROACH;
                        cnt_n   = 16'd0;
                        side_n  = lfsr_next[0];
                    end
                end
            end
            APPROACH: begin
                if (tick) begin
                    if (inpos) begin
                        cnt_n       = 16'd0;
                        collision_n = overlap;
                        dodge_n     = !overlap;
                        if (overlap)
                            lives_n = (lives != 4'd0) ? lives - 4'd1 : 4'd0;
                        else
                            score_n = (score != 16'hFFFF) ? score + 16'd1 : score;
                        state_n = (lives_n == 4'd0) ? GAME_OVER : COOLDOWN;
                    end else if (cnt_inc >= APPR_N) begin
                        state_n = COOLDOWN;
                        cnt_n   = 16'd0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= COOL_N) begin
                        state_n = SPAWN_WAIT;
                        cnt_n   = 16'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_barrier_collision_ctrl.sv
// tb_barrier_collision_ctrl: scoreboard bench for the barrier spawn/collision controller
module tb_barrier_collision_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, v_sync = 1'b0, start = 1'b0;
    logic        player_hit = 1'b0, hit_l = 1'b0, hit_r = 1'b0, inpos_l = 1'b0, inpos_r = 1'b0;
    logic        active_l, active_r, collision, dodge, game_over;
    logic [3:0]  lives;
    logic [15:0] score;

    typedef struct {
        bit          col;
        bit          dod;
        logic [3:0]  lives;
        logic [15:0] score;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, passes = 0;
    logic [7:0]  m_lfsr = 8'hA5;
    bit          m_running = 1'b0, m_side = 1'b0, act_before = 1'b0;
    logic [3:0]  m_lives = 4'd3;
    logic [15:0] m_score = 16'd0;
    int          early_act = 0;

    barrier_collision_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start),
        .i_player_hit(player_hit), .i_barrier_left_hit(hit_l), .i_barrier_right_hit(hit_r),
        .i_in_position_left(inpos_l), .i_in_position_right(inpos_r),
        .o_active_left(active_l), .o_active_right(active_r),
        .o_collision(collision), .o_dodge(dodge), .o_lives(lives), .o_score(score),
        .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Scoreboard: every pulse must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && (collision || dodge)) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pulse: unexpected col=%0b dodge=%0b lives=%0d score=%0d", collision, dodge, lives, score);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({collision, dodge, lives, score} !== {e.col, e.dod, e.lives, e.score})
                    $display("FAIL pulse: got col=%0b dodge=%0b lives=%0d score=%0d, want col=%0b dodge=%0b lives=%0d score=%0d",
                             collision, dodge, lives, score, e.col, e.dod, e.lives, e.score);
                else
                    passes++;
            end
        end
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic do_tick(input bit tick_ov);
        repeat (2) @(negedge clk);
        act_before = active_l | active_r;
        v_sync = 1'b1;
        if (tick_ov) begin
            player_hit = 1'b1;
            if (m_side) hit_r = 1'b1; else hit_l = 1'b1;
        end
        @(negedge clk);
        v_sync = 1'b0;
        if (tick_ov) begin
            player_hit = 1'b0;
            hit_r = 1'b0;
            hit_l = 1'b0;
        end
        if (m_running) m_lfsr = lfsr_step(m_lfsr);
        #1;
    endtask

    task automatic run_ticks(input int n, output int act);
        act = 0;
        for (int i = 0; i < n; i++) begin
            do_tick(1'b0);
            if (active_l | active_r) act++;
        end
    endtask

    task automatic spawn_after(input int n);
        run_ticks(n - 1, early_act);
        do_tick(1'b0);
        m_side = m_lfsr[0];
    endtask

    task automatic press_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_running = 1'b1;
        m_lives = 4'd3;
        m_score = 16'd0;
        #1;
    endtask

    task automatic resolve(input bit inp, input bit pix_ov, input bit tick_ov);
        @(negedge clk);
        if (inp) begin
            if (m_side) inpos_r = 1'b1; else inpos_l = 1'b1;
        end
        @(negedge clk);
        inpos_r = 1'b0;
        inpos_l = 1'b0;
        if (pix_ov) begin
            player_hit = 1'b1;
            if (m_side) hit_r = 1'b1; else hit_l = 1'b1;
        end
        @(negedge clk);
        player_hit = 1'b0;
        hit_r = 1'b0;
        hit_l = 1'b0;
        if (inp) begin
            if (pix_ov || tick_ov) begin
                m_lives = m_lives - 4'd1;
                exp_q.push_back('{1'b1, 1'b0, m_lives, m_score});
            end else begin
                m_score = m_score + 16'd1;
                exp_q.push_back('{1'b0, 1'b1, m_lives, m_score});
            end
        end
        do_tick(tick_ov);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({active_l, active_r, collision, dodge, game_over, lives, score} !== {5'b0, 4'd3, 16'd0})
            $display("FAIL reset: got actl=%0b actr=%0b col=%0b dodge=%0b go=%0b lives=%0d score=%0d, want 0 0 0 0 0 3 0",
                     active_l, active_r, collision, dodge, game_over, lives, score);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 8'hA5;
        m_running = 1'b0;
        m_lives = 4'd3;
        m_score = 16'd0;
    endtask

    task automatic test_spawn();
        press_start();
        spawn_after(30);
        checks++;
        if (early_act !== 0) $display("FAIL spawn_early: got %0d active ticks, want 0", early_act);
        else passes++;
        checks++;
        if (act_before !== 1'b0) $display("FAIL spawn_pre_edge: got active %0b before 30th tick, want 0", act_before);
        else passes++;
        checks++;
        if ({active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
            $display("FAIL spawn_side: got r/l=%b%b, want %b", active_r, active_l, m_side ? 2'b10 : 2'b01);
        else passes++;
    endtask

    task automatic test_collision();
        resolve(1'b1, 1'b1, 1'b0);
        checks++;
        if ({active_l, active_r, lives, exp_q.size() == 0} !== {2'b00, 4'd2, 1'b1})
            $display("FAIL collision: got act=%b%b lives=%0d pending=%0d, want act=00 lives=2 pending=0",
                     active_l, active_r, lives, exp_q.size());
        else passes++;
        spawn_after(45);
        checks++;
        if (early_act !== 0 || {active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
            $display("FAIL cooldown_respawn: got early=%0d r/l=%b%b, want early=0 side=%0b", early_act, active_r, active_l, m_side);
        else passes++;
    endtask

    task automatic test_dodge();
        resolve(1'b1, 1'b0, 1'b0);
        checks++;
        if ({active_l, active_r, score, lives, exp_q.size() == 0} !== {2'b00, 16'd1, 4'd2, 1'b1})
            $display("FAIL dodge: got act=%b%b score=%0d lives=%0d pending=%0d, want act=00 score=1 lives=2 pending=0",
                     active_l, active_r, score, lives, exp_q.size());
        else passes++;
        spawn_after(45);
        resolve(1'b1, 1'b0, 1'b1);
        checks++;
        if ({lives, score, exp_q.size() == 0} !== {4'd1, 16'd1, 1'b1})
            $display("FAIL tick_overlap: got lives=%0d score=%0d pending=%0d, want lives=1 score=1 pending=0",
                     lives, score, exp_q.size());
        else passes++;
        spawn_after(45);
        checks++;
        if (early_act !== 0 || {active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
            $display("FAIL dodge_respawn: got early=%0d r/l=%b%b, want early=0 side=%0b", early_act, active_r, active_l, m_side);
        else passes++;
    endtask

    task automatic test_timeout();
        int act;
        act = 0;
        player_hit = 1'b1;
        for (int i = 0; i < 59; i++) begin
            if (m_side) begin hit_l = 1'b1; inpos_l = i[0]; end
            else begin hit_r = 1'b1; inpos_r = i[0]; end
            if (i == 5) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            do_tick(1'b0);
            if (active_l | active_r) act++;
        end
        checks++;
        if (act !== 59) $display("FAIL approach_hold: got %0d active ticks, want 59", act);
        else passes++;
        do_tick(1'b0);
        checks++;
        if ({active_l, active_r, lives, score} !== {2'b00, m_lives, m_score})
            $display("FAIL timeout: got act=%b%b lives=%0d score=%0d, want act=00 lives=%0d score=%0d",
                     active_l, active_r, lives, score, m_lives, m_score);
        else passes++;
        player_hit = 1'b0;
        hit_l = 1'b0;
        hit_r = 1'b0;
        inpos_l = 1'b0;
        inpos_r = 1'b0;
        spawn_after(45);
        checks++;
        if (early_act !== 0 || {active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
            $display("FAIL timeout_respawn: got early=%0d r/l=%b%b, want early=0 side=%0b", early_act, active_r, active_l, m_side);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int act;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({active_l, active_r, collision, dodge, game_over, lives, score} !== {5'b0, 4'd3, 16'd0})
            $display("FAIL reset_mid: got actl=%0b actr=%0b col=%0b dodge=%0b go=%0b lives=%0d score=%0d, want 0 0 0 0 0 3 0",
                     active_l, active_r, collision, dodge, game_over, lives, score);
        else passes++;
        rst_n = 1'b1;
        m_lfsr = 8'hA5;
        m_running = 1'b0;
        m_lives = 4'd3;
        m_score = 16'd0;
        run_ticks(35, act);
        checks++;
        if (act !== 0) $display("FAIL idle_after_reset: got %0d active ticks, want 0", act);
        else passes++;
    endtask

    task automatic test_game_over();
        int act;
        press_start();
        for (int k = 0; k < 3; k++) begin
            spawn_after(k == 0 ? 30 : 45);
            checks++;
            if (early_act !== 0 || {active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
                $display("FAIL go_spawn%0d: got early=%0d r/l=%b%b, want early=0 side=%0b", k, early_act, active_r, active_l, m_side);
            else passes++;
            resolve(1'b1, 1'b1, 1'b0);
        end
        checks++;
        if ({game_over, lives, active_l, active_r} !== {1'b1, 4'd0, 2'b00})
            $display("FAIL game_over: got go=%0b lives=%0d act=%b%b, want go=1 lives=0 act=00", game_over, lives, active_l, active_r);
        else passes++;
        run_ticks(20, act);
        checks++;
        if (act !== 0 || game_over !== 1'b1)
            $display("FAIL game_over_hold: got active ticks=%0d go=%0b, want 0 and 1", act, game_over);
        else passes++;
        press_start();
        checks++;
        if ({game_over, lives, score} !== {1'b0, 4'd3, 16'd0})
            $display("FAIL restart: got go=%0b lives=%0d score=%0d, want go=0 lives=3 score=0", game_over, lives, score);
        else passes++;
        spawn_after(30);
        checks++;
        if (early_act !== 0 || {active_r, active_l} !== (m_side ? 2'b10 : 2'b01))
            $display("FAIL restart_spawn: got early=%0d r/l=%b%b, want early=0 side=%0b", early_act, active_r, active_l, m_side);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_collision();
        test_dodge();
        test_timeout();
        test_reset_mid();
        test_game_over();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending pulses, want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/barrier_collision_ctrl.md
Name: barrier_collision_ctrl

Overview:
- Game-side controller for the two perspective barrier sprites (left and right).
- Decides when a barrier spawns and which side it uses, and drives that barrier's `active` input.
- Consumes the barrier's per-pixel hit and `in_position` outputs together with the player sprite's hit output.
- Resolves each approach as a collision (lose a life) or a dodge (score +1) and tracks lives and game over.

Parameters:
- SPAWN_DELAY_FRAMES, 30, frames waited in SPAWN_WAIT before a barrier is activated
- COOLDOWN_FRAMES, 15, frames barrier kept inactive after resolution
- MAX_APPROACH_FRAMES, 60, frames allowed in APPROACH before timeout
- INIT_LIVES, 3, lives loaded on reset and on game start (1..15)
- LFSR_SEED, 8'hA5, non-zero side-select LFSR seed

Ports:
- i_clk  input  1  pixel clock, sole clock
- i_rst_n  input  1  synchronous active-low reset
- i_v_sync  input  1  vertical sync level, synchronous to i_clk
- i_start  input  1  one-cycle start request
- i_player_hit  input  1  player sprite opaque at current pixel
- i_barrier_left_hit  input  1  left barrier o_sprite_hit
- i_barrier_right_hit  input  1  right barrier o_sprite_hit
- i_in_position_left  input  1  left barrier in_position
- i_in_position_right  input  1  right barrier in_position
- o_active_left  output  1  drives left barrier active
- o_active_right  output  1  drives right barrier active
- o_collision  output  1  one-cycle pulse on collision
- o_dodge  output  1  one-cycle pulse on dodge
- o_lives  output  4  remaining lives
- o_score  output  16  dodge count
- o_game_over  output  1  high in GAME_OVER

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - o_active_left=0, o_active_right=0
  - o_collision=0, o_dodge=0
  - o_lives=INIT_LIVES, o_score=0, o_game_over=0
  - state=IDLE, LFSR=LFSR_SEED, all counters and flags 0
- Reset asserted mid-operation returns everything to these values on that edge.
- Frame tick:
  - `tick` = i_v_sync high AND registered previous i_v_sync low, i.e. a one-cycle pulse.
  - The registered copy resets to 0.
- LFSR:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4.
  - Shifts on every tick in every state except IDLE.
- Sticky frame flags overlap_f and inpos_f:
  - overlap_f sets on any cycle with i_player_hit AND the selected side's barrier_hit.
  - inpos_f sets on the selected side's in_position.
  - Both clear on the cycle after a tick.
  - Resolution on a tick uses (flag OR current-cycle condition), so the tick cycle belongs to the ending frame.
- States:
  - IDLE: actives 0. i_start -> load lives=INIT_LIVES and score=0, clear frame counter, go to SPAWN_WAIT.
  - SPAWN_WAIT:
    - Count ticks.
    - When the count reaches SPAWN_DELAY_FRAMES, latch side=LFSR[0] (1=right, 0=left) and go to APPROACH.
    - The selected o_active_* goes high on the next cycle.
  - APPROACH:
    - Exactly one o_active_* high, the one matching the latched side.
    - On tick with inpos true:
      - overlap true -> o_collision pulse, lives-1.
      - otherwise -> o_dodge pulse, score+1 (saturates at 16'hFFFF).
      - Then go to COOLDOWN if lives>0 after update, else GAME_OVER.
    - On tick with inpos false: increment the approach counter.
    - Counter reaching MAX_APPROACH_FRAMES -> COOLDOWN with no score or lives change.
  - COOLDOWN: actives 0. After COOLDOWN_FRAMES ticks -> SPAWN_WAIT with counter cleared.
  - GAME_OVER: actives 0, o_game_over=1. i_start -> behaves as IDLE start.
- i_start is ignored in SPAWN_WAIT, APPROACH and COOLDOWN.
- Off-side hit and in_position inputs are ignored.
- o_collision and o_dodge are registered pulses, asserted for exactly one cycle on the cycle after the resolving tick, and mutually exclusive.
- Lives never underflow: a collision at lives=1 gives 0 and GAME_OVER.

Test Plan:
- Reset with i_rst_n=0 mid-APPROACH -> next edge: actives 0, lives=3, score=0, state IDLE, no pulses.
- Start with defaults, no hits -> after 30 ticks exactly one active high, with the side equal to LFSR[0] after 30 shifts from 8'hA5; o_active_* rises 1 cycle after the 30th tick.
- Selected side asserts in_position for one frame, player_hit and barrier_hit overlap on one pixel in that frame -> one o_collision pulse, lives 3->2, actives drop, 15 ticks later SPAWN_WAIT.
- Same as previous but with no overlap; separately, overlap asserted only on the tick cycle itself -> first case gives o_dodge and score 0->1, tick-cycle case counts as collision.
- Three successive collisions -> lives 0, o_game_over=1, actives stay 0; i_start -> lives=3, score=0, SPAWN_WAIT.
- in_position never asserted -> after 60 approach ticks COOLDOWN, lives and score unchanged, no pulses; opposite-side in_position and hit toggling throughout has no effect.
